// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: operation encoding, FSM states
// and bit positions of the flags inside the packed flag vector.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_MAX = 4'd6,
        OP_MIN = 4'd7,
        OP_ABS = 4'd8,
        OP_SHR = 4'd9,
        OP_SHL = 4'd10,
        OP_MUL = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Flag bit positions inside a [NUM_FLAGS-1:0] vector
    localparam int FLAG_N    = 0;
    localparam int FLAG_Z    = 1;
    localparam int FLAG_OF   = 2;
    localparam int FLAG_E    = 3;
    localparam int FLAG_CO   = 4;
    localparam int NUM_FLAGS = 5;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle datapath of the ALU (ADD..ABS) with flag generation.
// Any op code outside 0..8 yields a zero result and all flags cleared; the
// top level overrides that for the shift and multiply ops it handles itself.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]           i_op,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic                 i_ci,
    output logic [WIDTH-1:0]     o_r,
    output logic [NUM_FLAGS-1:0] o_flags
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_neg_a;
    logic [WIDTH-1:0] w_res;
    logic             w_legal;
    logic             w_of;
    logic             w_co;

    // Result, overflow and carry for every single-cycle op
    always_comb begin
        w_sum   = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_ci};
        w_diff  = i_a - i_b;
        w_neg_a = '0 - i_a;
        w_res   = '0;
        w_legal = 1'b1;
        w_of    = 1'b0;
        w_co    = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_co  = w_sum[WIDTH];
                w_of  = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff;
                w_co  = (i_a >= i_b);
                w_of  = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND: w_res = i_a & i_b;
            OP_OR:  w_res = i_a | i_b;
            OP_XOR: w_res = i_a ^ i_b;
            OP_NOT: w_res = ~i_a;
            OP_MAX: w_res = ($signed(i_a) > $signed(i_b)) ? i_a : i_b;
            OP_MIN: w_res = ($signed(i_a) < $signed(i_b)) ? i_a : i_b;
            OP_ABS: begin
                // The most negative value has no positive counterpart: pass it through and flag it
                if (i_a == MOST_NEG) begin
                    w_res = i_a;
                    w_of  = 1'b1;
                end else begin
                    w_res = i_a[WIDTH-1] ? w_neg_a : i_a;
                end
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Pack result and flags; illegal ops report nothing at all
    always_comb begin
        o_r     = '0;
        o_flags = '0;
        if (w_legal) begin
            o_r              = w_res;
            o_flags[FLAG_N]  = w_res[WIDTH-1];
            o_flags[FLAG_Z]  = (w_res == '0);
            o_flags[FLAG_OF] = w_of;
            o_flags[FLAG_E]  = (i_a == i_b);
            o_flags[FLAG_CO] = w_co;
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: IDLE/EXEC/DONE controller, bit-serial shifter and optional
// shift-add multiplier around the single-cycle alu_comb datapath.
// Optional feature: define MULTICYCLE_ALU_MUL_EN to build the multiplier
// (op 11); without it op 11 is treated as an illegal op.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             si,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             n,
    output logic             z,
    output logic             of,
    output logic             e,
    output logic             co
);

    localparam int SW = $clog2(WIDTH);

    state_e               r_state;
    logic [3:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_si;
    logic                 r_ci;
    logic [SW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_sh;
    logic                 r_busy;
    logic                 r_done;
    logic [WIDTH-1:0]     r_res;
    logic [NUM_FLAGS-1:0] r_flags;

    logic [WIDTH-1:0]     w_comb_r;
    logic [NUM_FLAGS-1:0] w_comb_flags;
    logic [SW-1:0]        w_shamt;
    logic [WIDTH-1:0]     w_sh_next;
    logic                 w_sh_out;
    logic [SW-1:0]        w_start_cnt;
    logic [WIDTH-1:0]     w_fin_r;
    logic [NUM_FLAGS-1:0] w_fin_flags;

`ifdef MULTICYCLE_ALU_MUL_EN
    logic [WIDTH-1:0]     r_prod;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH/2-1:0]   r_mplier;
    logic [WIDTH-1:0]     w_prod_next;

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
    end
`endif

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .i_op    (r_op),
        .i_a     (r_a),
        .i_b     (r_b),
        .i_ci    (r_ci),
        .o_r     (w_comb_r),
        .o_flags (w_comb_flags)
    );

    assign w_shamt = r_b[SW-1:0];

    // One-bit shift step; a zero shift amount leaves the operand untouched with no bit out
    always_comb begin
        w_sh_next = r_sh;
        w_sh_out  = 1'b0;
        if (w_shamt != '0) begin
            if (r_op == OP_SHR) begin
                w_sh_next = {r_si, r_sh[WIDTH-1:1]};
                w_sh_out  = r_sh[0];
            end else begin
                w_sh_next = {r_sh[WIDTH-2:0], r_si};
                w_sh_out  = r_sh[WIDTH-1];
            end
        end
    end

    // Number of extra EXEC cycles after the first, derived from the request being accepted
    always_comb begin
        w_start_cnt = '0;
        case (op)
            OP_SHR, OP_SHL: begin
                if (b[SW-1:0] != '0) w_start_cnt = b[SW-1:0] - SW'(1);
            end
`ifdef MULTICYCLE_ALU_MUL_EN
            OP_MUL: w_start_cnt = SW'(WIDTH/2 - 1);
`endif
            default: w_start_cnt = '0;
        endcase
    end

    // Select the value committed on entry to DONE
    always_comb begin
        w_fin_r     = w_comb_r;
        w_fin_flags = w_comb_flags;
        if (r_op == OP_SHR || r_op == OP_SHL) begin
            w_fin_r              = w_sh_next;
            w_fin_flags          = '0;
            w_fin_flags[FLAG_N]  = w_sh_next[WIDTH-1];
            w_fin_flags[FLAG_Z]  = (w_sh_next == '0);
            w_fin_flags[FLAG_E]  = (r_a == r_b);
            w_fin_flags[FLAG_CO] = w_sh_out;
        end
`ifdef MULTICYCLE_ALU_MUL_EN
        if (r_op == OP_MUL) begin
            w_fin_r             = w_prod_next;
            w_fin_flags         = '0;
            w_fin_flags[FLAG_N] = w_prod_next[WIDTH-1];
            w_fin_flags[FLAG_Z] = (w_prod_next == '0);
            w_fin_flags[FLAG_E] = (r_a == r_b);
        end
`endif
    end

    // Controller: accept in IDLE/DONE, iterate in EXEC, commit results on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_si     <= 1'b0;
            r_ci     <= 1'b0;
            r_cnt    <= '0;
            r_sh     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_res    <= '0;
            r_flags  <= '0;
`ifdef MULTICYCLE_ALU_MUL_EN
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op     <= op;
                        r_a      <= a;
                        r_b      <= b;
                        r_si     <= si;
                        r_ci     <= ci;
                        r_sh     <= a;
                        r_cnt    <= w_start_cnt;
`ifdef MULTICYCLE_ALU_MUL_EN
                        r_prod   <= '0;
                        r_mcand  <= {{(WIDTH/2){1'b0}}, a[WIDTH/2-1:0]};
                        r_mplier <= b[WIDTH/2-1:0];
`endif
                        r_busy   <= 1'b1;
                        r_state  <= ST_EXEC;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    r_sh     <= w_sh_next;
`ifdef MULTICYCLE_ALU_MUL_EN
                    r_prod   <= w_prod_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
`endif
                    if (r_cnt == '0) begin
                        r_res   <= w_fin_r;
                        r_flags <= w_fin_flags;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt   <= r_cnt - SW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign r    = r_res;
    assign n    = r_flags[FLAG_N];
    assign z    = r_flags[FLAG_Z];
    assign of   = r_flags[FLAG_OF];
    assign e    = r_flags[FLAG_E];
    assign co   = r_flags[FLAG_CO];

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=8). A timing/arithmetic model
// predicts busy/done/result/flags every cycle; directed cases pin literal values.
// Honours MULTICYCLE_ALU_MUL_EN the same way as the design.
module tb_multicycle_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, si, ci;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, n, z, of, e, co;
    logic [W-1:0] r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .si(si), .ci(ci), .busy(busy), .done(done), .r(r),
        .n(n), .z(z), .of(of), .e(e), .co(co)
    );

    // Arithmetic reference: result, flags {n,z,of,e,co} and EXEC length
    function automatic void model(input logic [3:0] f_op, input logic [7:0] f_a, input logic [7:0] f_b,
                                  input logic f_si, input logic f_ci,
                                  output logic [7:0] f_r, output logic [4:0] f_fl, output int f_n);
        int ua, ub, sa, sb, t, s, cin;
        logic ofv, cov, legal;
        ua = f_a; ub = f_b; cin = f_ci;
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        t = 0; ofv = 0; cov = 0; legal = 1; f_n = 1; s = ub % W;
        case (f_op)
            4'd0: begin t = ua + ub + cin; cov = (t > 255); ofv = (sa + sb + cin > 127) || (sa + sb + cin < -128); end
            4'd1: begin t = ua - ub; cov = (ua >= ub); ofv = (sa - sb > 127) || (sa - sb < -128); end
            4'd2: t = ua & ub;
            4'd3: t = ua | ub;
            4'd4: t = ua ^ ub;
            4'd5: t = 255 - ua;
            4'd6: t = (sa >= sb) ? ua : ub;
            4'd7: t = (sa <= sb) ? ua : ub;
            4'd8: begin
                if (ua == 128) begin t = 128; ofv = 1; end
                else t = (sa < 0) ? -sa : sa;
            end
            4'd9: begin
                if (s == 0) t = ua;
                else begin
                    t = (ua >> s) | (f_si ? (255 << (8 - s)) : 0);
                    cov = ((ua >> (s - 1)) % 2) == 1;
                    f_n = s;
                end
            end
            4'd10: begin
                if (s == 0) t = ua;
                else begin
                    t = (ua << s) | (f_si ? ((1 << s) - 1) : 0);
                    cov = ((ua >> (8 - s)) % 2) == 1;
                    f_n = s;
                end
            end
`ifdef MULTICYCLE_ALU_MUL_EN
            4'd11: begin t = (ua % 16) * (ub % 16); f_n = 4; end
`endif
            default: legal = 0;
        endcase
        f_r  = legal ? 8'(t) : 8'h00;
        f_fl = legal ? {f_r[7], f_r == 8'h00, ofv, f_a == f_b, cov} : 5'b0;
    endfunction

    // Timeline model: an accepted request at edge k ends at edge k+N
    int         edge_no  = 0;
    int         end_edge = 0;
    bit         pend     = 0;
    int         nn;
    logic [7:0] p_r, exp_r = '0;
    logic [4:0] p_fl, exp_fl = '0;
    logic       exp_busy = 0, exp_done = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend = 0; exp_r = '0; exp_fl = '0; exp_busy = 0; exp_done = 0;
        end else begin
            edge_no++;
            if (pend && edge_no == end_edge) begin
                exp_r  = p_r;
                exp_fl = p_fl;
            end
            if (start && (!pend || edge_no > end_edge)) begin
                model(op, a, b, si, ci, p_r, p_fl, nn);
                end_edge = edge_no + nn;
                pend = 1;
            end
            exp_busy = pend && (edge_no < end_edge);
            exp_done = pend && (edge_no == end_edge);
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        checks++;
        if ({busy, done, r, n, z, of, e, co} !== {exp_busy, exp_done, exp_r, exp_fl}) begin
            errors++;
            $display("FAIL cycle t=%0t got busy=%b done=%b r=%h nzoec=%b%b%b%b%b want busy=%b done=%b r=%h nzoec=%b",
                     $time, busy, done, r, n, z, of, e, co, exp_busy, exp_done, exp_r, exp_fl);
        end
    end

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Launch one op, wait for done (bounded), check latency, busy length, result
    task automatic run_op(input string name, input logic [3:0] t_op, input logic [7:0] t_a, input logic [7:0] t_b,
                          input logic t_si, input logic t_ci, input int lat_req,
                          input logic [7:0] r_req, input logic [4:0] fl_req, input bit poke);
        int lat, busy_cnt;
        @(negedge clk);
        op = t_op; a = t_a; b = t_b; si = t_si; ci = t_ci; start = 1;
        lat = 0; busy_cnt = 0;
        do begin
            @(negedge clk);
            start = 0;
            op = 4'($urandom_range(0, 15)); a = 8'($urandom); b = 8'($urandom);
            lat++;
            if (busy) busy_cnt++;
            if (poke && lat == 2) start = 1;
        end while (!done && lat < 40);
        $display("op %s a=%h b=%h -> r=%h nzoec=%b%b%b%b%b latency=%0d", name, t_a, t_b, r, n, z, of, e, co, lat);
        check_val({name, "_latency"}, 32'(lat), 32'(lat_req));
        check_val({name, "_busy_cycles"}, 32'(busy_cnt), 32'(lat_req - 1));
        check_val({name, "_result"}, {19'b0, r, n, z, of, e, co}, {19'b0, r_req, fl_req});
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [7:0] mr;
        logic [4:0] mf;
        int         mn, dcount, lat;

        rst = 1; start = 0; op = '0; a = '0; b = '0; si = 0; ci = 0;

        // Pin the model with hand-computed values
        model(4'd0, 8'hBA, 8'hAE, 1'b0, 1'b1, mr, mf, mn);
        check_val("model_add", {mr, mf, 8'(mn)}, {8'h69, 5'b00101, 8'd1});
        model(4'd9, 8'hBA, 8'h03, 1'b1, 1'b0, mr, mf, mn);
        check_val("model_shr", {mr, mf, 8'(mn)}, {8'hF7, 5'b10000, 8'd3});
        model(4'd8, 8'h80, 8'h00, 1'b0, 1'b0, mr, mf, mn);
        check_val("model_abs", {mr, mf, 8'(mn)}, {8'h80, 5'b10100, 8'd1});

        repeat (2) @(negedge clk);
        check_val("reset_state", {19'b0, busy, done, r, n, z, of, e, co}, 32'h0);
        rst = 0;

        run_op("ADD", 4'd0, 8'hBA, 8'hAE, 1'b0, 1'b1, 2, 8'h69, 5'b00101, 0);
        run_op("SUB", 4'd1, 8'hBA, 8'hAE, 1'b0, 1'b0, 2, 8'h0C, 5'b00001, 0);
        run_op("ABS", 4'd8, 8'h80, 8'h00, 1'b0, 1'b0, 2, 8'h80, 5'b10100, 0);
        run_op("SHR", 4'd9, 8'hBA, 8'h03, 1'b1, 1'b0, 4, 8'hF7, 5'b10000, 0);
        run_op("SHL0", 4'd10, 8'h5A, 8'h08, 1'b1, 1'b0, 2, 8'h5A, 5'b00000, 0);
        run_op("SHL1", 4'd10, 8'h81, 8'h01, 1'b0, 1'b0, 2, 8'h02, 5'b00001, 0);
        run_op("ILLEGAL", 4'd13, 8'h33, 8'h33, 1'b1, 1'b1, 2, 8'h00, 5'b00000, 0);
`ifdef MULTICYCLE_ALU_MUL_EN
        run_op("MUL", 4'd11, 8'hBA, 8'hAE, 1'b0, 1'b0, 5, 8'h8C, 5'b10000, 0);
`else
        run_op("MUL", 4'd11, 8'hBA, 8'hAE, 1'b0, 1'b0, 2, 8'h00, 5'b00000, 0);
`endif
        // Start pulsed while busy must be ignored
        run_op("SHR7_POKE", 4'd9, 8'hBA, 8'h07, 1'b0, 1'b0, 8, 8'h01, 5'b00000, 1);

        // Back-to-back: ADD, then SUB launched in ADD's DONE cycle
        run_op("ADD_B2B", 4'd0, 8'hBA, 8'hAE, 1'b0, 1'b1, 2, 8'h69, 5'b00101, 0);
        op = 4'd1; a = 8'hBA; b = 8'hAE; ci = 0; start = 1;
        @(negedge clk);
        start = 0;
        check_val("b2b_busy_next", {30'b0, busy, done}, 32'b10);
        lat = 1;
        while (!done && lat < 40) begin @(negedge clk); lat++; end
        $display("op SUB_B2B a=ba b=ae -> r=%h latency=%0d", r, lat);
        check_val("b2b_result", {24'b0, r}, 32'h0C);

        // Reset in the middle of a multiply
        @(negedge clk);
        op = 4'd11; a = 8'hBA; b = 8'hAE; start = 1;
        @(negedge clk);
        start = 0;
        #2 rst = 1;
        #1 check_val("rst_mid_op", {19'b0, busy, done, r, n, z, of, e, co}, 32'h0);
        @(negedge clk);
        #2 rst = 0;
        dcount = 0;
        repeat (8) begin @(negedge clk); if (done) dcount++; end
        $display("reset mid-op: done pulses afterwards=%0d", dcount);
        check_val("no_done_after_rst", 32'(dcount), 32'd0);

        // First start accepted on the first edge after reset release
        @(negedge clk); #2 rst = 1;
        @(negedge clk); rst = 0; op = 4'd2; a = 8'hF0; b = 8'h3C; start = 1;
        @(negedge clk); start = 0;
        check_val("start_after_rst", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check_val("and_after_rst", {19'b0, r, n, z, of, e, co}, {19'b0, 8'h30, 5'b00000});

        // Randomized traffic, including starts during busy and occasional resets
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? a : 8'($urandom);
            si = 1'($urandom);
            ci = 1'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1;
                @(negedge clk);
                #2 rst = 0;
            end
        end
        start = 0;
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
